// File: rtl/ksa_shuffle_ctrl.sv
// RC4 key-scheduling shuffle sequencer: walks i over S[0..255] on a single-port
// 256x8 memory, accumulating j and swapping S[i]/S[j] in six cycles per step.
module ksa_shuffle_ctrl #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic                   busy,
    output logic                   finish
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE
    } state_e;

    state_e                 state_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i_q, j_q, si_q, sj_q;
    logic [KW-1:0]          k_q;
    logic [7:0]             addr_q, wdata_q;
    logic                   wren_q, busy_q, finish_q;

    logic [7:0]             kb;
    logic [7:0]             j_d;
    logic [KW-1:0]          k_d;

    // Key byte 0 sits in the most-significant byte of the latched key.
    always_comb begin
        kb = '0;
        for (int n = 0; n < KEY_BYTES; n++)
            if (k_q == KW'(n)) kb = key_q[8*(KEY_BYTES-1-n) +: 8];
    end

    assign j_d = j_q + mem_rdata + kb;
    assign k_d = (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + 1'b1;

    // Output registers are loaded with the values belonging to the state being
    // entered, so they behave as Moore outputs of the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RD_I;
                        key_q   <= secret_key;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        addr_q  <= '0;
                        wren_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RD_I: state_q <= WAIT_I;
                WAIT_I: begin
                    state_q <= RD_J;
                    si_q    <= mem_rdata;
                    j_q     <= j_d;
                    addr_q  <= j_d;
                end
                RD_J: state_q <= WAIT_J;
                WAIT_J: begin
                    state_q <= WR_I;
                    sj_q    <= mem_rdata;
                    addr_q  <= i_q;
                    wdata_q <= mem_rdata;
                    wren_q  <= 1'b1;
                end
                WR_I: begin
                    state_q <= WR_J;
                    addr_q  <= j_q;
                    wdata_q <= si_q;
                    wren_q  <= 1'b1;
                end
                WR_J: begin
                    wren_q <= 1'b0;
                    if (i_q == 8'hFF) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                    end else begin
                        state_q <= RD_I;
                        i_q     <= i_q + 8'd1;
                        k_q     <= k_d;
                        addr_q  <= i_q + 8'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q  <= IDLE;
                        finish_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wren  = wren_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_ksa_shuffle_ctrl.sv
// Bench for ksa_shuffle_ctrl: behavioural S memory, software KSA model feeding a
// write scoreboard, plus latency, pulse-start and mid-run reset scenarios.
module tb_ksa_shuffle_ctrl;

    localparam int KB = 3;

    logic          clk, reset_n, start;
    logic [8*KB-1:0] secret_key;
    logic [7:0]    mem_addr, mem_wdata, mem_rdata;
    logic          mem_wren, busy, finish;

    ksa_shuffle_ctrl #(.KEY_BYTES(KB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .busy(busy), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t exp_q[$];
    logic [7:0] sm [256];
    logic [7:0] lg_a [6];
    logic [7:0] lg_d [6];

    int n_cmp = 0, n_err = 0;
    int wr_cnt = 0;
    logic prev_wren = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Software KSA; pushes the expected (addr,data) of every write in order.
    task automatic model(input logic [8*KB-1:0] key);
        logic [7:0] j, t, kbyte;
        for (int n = 0; n < 256; n++) sm[n] = 8'(n);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kbyte = key[8*(KB-1-(i % KB)) +: 8];
            j = j + sm[i] + kbyte;
            exp_q.push_back('{addr: 8'(i), data: sm[j]});
            exp_q.push_back('{addr: j, data: sm[i]});
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
        end
    endtask

    task automatic fill();
        for (int n = 0; n < 256; n++) mem[n] = 8'(n);
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_wren) begin
            wr_t e;
            if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
            end
            chk("wr_pair", {31'd0, prev_wren}, {31'd0, wr_cnt[0]});
            if (wr_cnt < 6) begin
                lg_a[wr_cnt] = mem_addr;
                lg_d[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
        end
        prev_wren = reset_n && mem_wren;
    end

    task automatic run(input logic [8*KB-1:0] key, input bit pulse);
        int cyc, bcnt;
        fill();
        exp_q.delete();
        model(key);
        wr_cnt = 0;
        secret_key = key;
        start = 1'b1;
        @(negedge clk);
        if (pulse) start = 1'b0;
        secret_key = ~key;
        chk("busy_rise", {31'd0, busy}, 1);
        cyc = 0; bcnt = 0;
        while (!finish && cyc < 3000) begin
            bcnt += busy;
            cyc++;
            @(negedge clk);
        end
        chk("latency", cyc, 1536);
        chk("busy_cycles", bcnt, 1536);
        chk("wr_count", wr_cnt, 512);
        chk("queue_left", exp_q.size(), 0);
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_wren", {31'd0, mem_wren}, 0);
        for (int n = 0; n < 256; n++)
            chk($sformatf("final[%0d]", n), {24'd0, mem[n]}, {24'd0, sm[n]});
        if (!pulse) begin
            repeat (3) @(negedge clk);
            chk("done_hold", {31'd0, finish}, 1);
            start = 1'b0;
        end
        @(negedge clk);
        chk("done_exit", {31'd0, finish}, 0);
        repeat (20) @(negedge clk);
        chk("no_rerun_wr", wr_cnt, 512);
        chk("no_rerun_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; start = 1'b0; secret_key = '0;
        #12;
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_wren", {31'd0, mem_wren}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_finish", {31'd0, finish}, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_wr", wr_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_finish", {31'd0, finish}, 0);
        chk("idle_addr", {24'd0, mem_addr}, 0);

        run(24'h000000, 1'b0);
        chk("it0_a0", {24'd0, lg_a[0]}, 0); chk("it0_d0", {24'd0, lg_d[0]}, 0);
        chk("it0_a1", {24'd0, lg_a[1]}, 0); chk("it0_d1", {24'd0, lg_d[1]}, 0);
        chk("it1_a0", {24'd0, lg_a[2]}, 1); chk("it1_d0", {24'd0, lg_d[2]}, 1);
        chk("it1_a1", {24'd0, lg_a[3]}, 1); chk("it1_d1", {24'd0, lg_d[3]}, 1);
        chk("it2_a0", {24'd0, lg_a[4]}, 2); chk("it2_d0", {24'd0, lg_d[4]}, 3);
        chk("it2_a1", {24'd0, lg_a[5]}, 3); chk("it2_d1", {24'd0, lg_d[5]}, 2);

        run(24'h000249, 1'b1);

        // Abort at i=100 while in RD_J, then refill and rerun.
        fill();
        exp_q.delete();
        model(24'h000249);
        wr_cnt = 0;
        secret_key = 24'h000249;
        start = 1'b1;
        cyc = 0;
        while (wr_cnt < 200 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_reach", {31'd0, wr_cnt == 200}, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_pre_busy", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_addr", {24'd0, mem_addr}, 0);
        chk("abort_wdata", {24'd0, mem_wdata}, 0);
        chk("abort_wren", {31'd0, mem_wren}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_finish", {31'd0, finish}, 0);
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);

        run(24'h000249, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ksa_shuffle_ctrl.md
Name: ksa_shuffle_ctrl

Overview:
- Sequences the RC4 key-scheduling shuffle over the 256x8 single-port S memory, after the identity fill (S[i]=i) has completed.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i] and S[j].
- Sole owner of the S memory port while busy. Upstream fill logic hands over via start; downstream logic (PRGA) waits for finish.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; key byte 0 is the most-significant byte of secret_key.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level request; shuffle begins when high in IDLE
- secret_key  in  8*KEY_BYTES  key; latched on leaving IDLE
- mem_addr  out  8  S memory address
- mem_wdata  out  8  S memory write data
- mem_wren  out  1  S memory write enable
- mem_rdata  in  8  S memory read data; valid in the cycle after the address cycle with wren=0
- busy  out  1  high from leaving IDLE until entering DONE
- finish  out  1  high while in DONE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; i=0, j=0, k=0, si=0, sj=0.
  - mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, finish=0.
- Outputs are Moore, decoded from registered state and counters. mem_wren=1 only in WR_I and WR_J.
- States and transitions:
  - IDLE: start=1 -> RD_I; latch secret_key; i=0, j=0, k=0.
  - RD_I: mem_addr=i, wren=0 -> WAIT_I.
  - WAIT_I: si<=mem_rdata; j<=j+mem_rdata+keybyte[k] (mod 256, 8-bit wrap) -> RD_J.
  - RD_J: mem_addr=j (updated value), wren=0 -> WAIT_J.
  - WAIT_J: sj<=mem_rdata -> WR_I.
  - WR_I: mem_addr=i, mem_wdata=sj, wren=1 -> WR_J.
  - WR_J: mem_addr=j, mem_wdata=si, wren=1.
    - If i=255 -> DONE.
    - Else i<=i+1; k<=(k==KEY_BYTES-1)?0:k+1 -> RD_I.
  - DONE: finish=1, busy=0. start=0 -> IDLE. start=1 -> stay in DONE.
- k is a wrapping counter; no divider or modulo operator. i and j are 8-bit and wrap naturally.
- Latency: 6 cycles per iteration, 1536 cycles from the first RD_I to the first DONE cycle.
- i==j: WR_I writes sj(=si) and WR_J writes si to the same address; net no-op, which is the required result.
- start dropped mid-shuffle: ignored; the shuffle completes and DONE lasts exactly one cycle, then IDLE.
- Restart requires passing through IDLE (start low, then high). The previous shuffle result is reshuffled unless upstream refills the memory first.
- secret_key changes after latching: no effect until the next run.
- reset_n asserted mid-operation: immediate return to IDLE with reset values. Memory contents are left partially shuffled and must be refilled before the next run.

Test Plan:
- Reset, then hold start=0 for 10 cycles -> all outputs 0, state IDLE, no memory writes.
- Memory filled with identity, key 0x000000, start=1:
  - Iteration 0 writes addr0=0 twice; iteration 1 writes addr1=1 twice.
  - Iteration 2: j=3, writes addr2=3, then addr3=2.
- Identity fill, key 0x000249, start=1 -> final 256 S bytes match the software RC4 KSA model exactly; finish rises 1536 cycles after the first RD_I; busy high throughout.
- Write-pattern check: exactly 512 wren=1 cycles per run, always in consecutive WR_I/WR_J pairs at addresses (i, j), where i increments 0..255.
- start pulsed for 1 cycle only -> full run completes; finish high for exactly 1 cycle; return to IDLE; no second run starts.
- reset_n=0 at iteration i=100 (mid RD_J) -> outputs 0 asynchronously. Refill the memory and restart with key 0x000249 -> final contents identical to the clean run.
